// File: rtl/pipe_pkg.sv
// Shared types and constants for valid/ready pipeline stage registers.
// Default widths describe the MEM/WB boundary of the core.
package pipe_pkg;

    // Occupancy of a skid stage: main slot drives the outputs,
    // the skid slot holds the younger beat while main is stalled.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam int MEMWB_PAYLOAD_W = 103;
    localparam int MEMWB_CTRL_W    = 4;
    localparam int MEMWB_HALT_BIT  = 3;

    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] data_alu;
        logic [31:0] dm_out;
        logic [4:0]  rd;
        logic [1:0]  spare;
    } memwb_payload_t;

    // ebreak sits in the MSB so that it lands on MEMWB_HALT_BIT.
    typedef struct packed {
        logic       ebreak;
        logic [1:0] ru_data_wr_src;
        logic       ru_wr;
    } memwb_ctrl_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat bundle: payload plus control field.
// master drives valid/payload/ctrl, slave drives ready.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_PAYLOAD_W,
    parameter int CTRL_W    = MEMWB_CTRL_W
);

    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;
    logic [CTRL_W-1:0]    ctrl;

    modport master (
        output valid,
        output payload,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  payload,
        input  ctrl,
        output ready
    );

endinterface

// File: rtl/pipe_slot.sv
// One beat register: valid bit, payload and control.
// Ports: clk, rst_n, clr (kill, priority), load, d_payload/d_ctrl in; valid/payload/ctrl out.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                PAYLOAD_W = MEMWB_PAYLOAD_W,
    parameter int                CTRL_W    = MEMWB_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [CTRL_W-1:0]    d_ctrl,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [CTRL_W-1:0]    ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '0;
            ctrl    <= CTRL_NOP;
        end else if (clr) begin
            valid   <= 1'b0;
            payload <= '0;
            ctrl    <= CTRL_NOP;
        end else if (load) begin
            valid   <= 1'b1;
            payload <= d_payload;
            ctrl    <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and optional 2-entry skid.
// Ports: clk, rst_n, flush; in_if (slave), out_if (master); halt_o sticky; stall_cnt saturating.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                PAYLOAD_W = MEMWB_PAYLOAD_W,
    parameter int                CTRL_W    = MEMWB_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP  = '0,
    parameter int                HALT_BIT  = MEMWB_HALT_BIT,
    parameter bit                SKID_EN   = 1'b1,
    parameter int                CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    pipe_stage_skid_if.slave         in_if,
    pipe_stage_skid_if.master        out_if,
    output logic                     halt_o,
    output logic [CNT_W-1:0]         stall_cnt
);

    occ_t state;
    occ_t nxt;

    logic in_ready;
    logic acc;
    logic dep;

    logic main_load;
    logic main_clr;
    logic skid_load;
    logic skid_clr;

    logic                 main_v;
    logic [PAYLOAD_W-1:0] main_payload;
    logic [CTRL_W-1:0]    main_ctrl;
    logic [PAYLOAD_W-1:0] main_d_payload;
    logic [CTRL_W-1:0]    main_d_ctrl;

    logic                 skid_v;
    logic [PAYLOAD_W-1:0] skid_payload;
    logic [CTRL_W-1:0]    skid_ctrl;

    // With skid, in_ready depends only on the state register, so there
    // is no combinational path from out_ready back to in_ready.
    assign in_ready = SKID_EN ? (state != OCC_FULL)
                              : (!main_v || out_if.ready);

    assign acc = in_if.valid && in_ready;
    assign dep = main_v && out_if.ready;

    // Main refills from skid whenever skid holds the older waiting beat.
    assign main_d_payload = skid_v ? skid_payload : in_if.payload;
    assign main_d_ctrl    = skid_v ? skid_ctrl    : in_if.ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            // A beat offered this cycle is dropped together with held ones.
            nxt      = OCC_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (SKID_EN) begin
            unique case (state)
                OCC_EMPTY: begin
                    if (acc) begin
                        main_load = 1'b1;
                        nxt       = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (acc && dep) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        skid_load = 1'b1;
                        nxt       = OCC_FULL;
                    end else if (dep) begin
                        main_clr = 1'b1;
                        nxt      = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (dep) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        nxt       = OCC_ONE;
                    end
                end
                default: begin
                    nxt      = OCC_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end else begin
            if (acc) begin
                main_load = 1'b1;
                nxt       = OCC_ONE;
            end else if (dep) begin
                main_clr = 1'b1;
                nxt      = OCC_EMPTY;
            end
        end
    end

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W),
        .CTRL_NOP  (CTRL_NOP)
    ) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (main_clr),
        .load      (main_load),
        .d_payload (main_d_payload),
        .d_ctrl    (main_d_ctrl),
        .valid     (main_v),
        .payload   (main_payload),
        .ctrl      (main_ctrl)
    );

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W),
        .CTRL_NOP  (CTRL_NOP)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (skid_clr),
        .load      (skid_load),
        .d_payload (in_if.payload),
        .d_ctrl    (in_if.ctrl),
        .valid     (skid_v),
        .payload   (skid_payload),
        .ctrl      (skid_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_o <= 1'b0;
        end else if (dep && main_ctrl[HALT_BIT]) begin
            halt_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_v && !out_if.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign in_if.ready    = in_ready;
    assign out_if.valid   = main_v;
    assign out_if.payload = main_payload;
    assign out_if.ctrl    = main_v ? main_ctrl : CTRL_NOP;

endmodule
